// File: rtl/apb4_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb4_master_pkg
//  Purpose  : Shared types for the APB4 requester (FSM states, command record)
//  Revision : 1.0 - initial release
// ============================================================================
package apb4_master_pkg;

  // APB4 caps PADDR/PDATA at 32 bits; the command record is sized for that.
  localparam int c_AW_MAX = 32;
  localparam int c_DW_MAX = 32;
  localparam int c_SW_MAX = c_DW_MAX / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [c_AW_MAX-1:0] addr;
    logic                write;
    logic [c_DW_MAX-1:0] wdata;
    logic [c_SW_MAX-1:0] strb;
    logic [2:0]          prot;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb4_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb4_master
//  Purpose  : APB4 requester bridging a valid/ready command channel to APB4,
//             with a pready watchdog that aborts hung transfers
//  Revision : 1.0 - initial release
// ============================================================================
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // command channel
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic            cmd_write_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_strb_i,
  input  logic [2:0]      cmd_prot_i,
  // response channel
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            rsp_timeout_o,
  // APB4 requester interface
  output logic [AW-1:0]   paddr_o,
  output logic [2:0]      pprot_o,
  output logic            pwrite_o,
  output logic [DW-1:0]   pwdata_o,
  output logic [DW/8-1:0] pstrb_o,
  output logic            psel_o,
  output logic            penable_o,
  input  logic            pready_i,
  input  logic [DW-1:0]   prdata_i,
  input  logic            pslverr_i
);

  localparam int c_SW = DW / 8;
  localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_CW-1:0] c_TMO_LAST = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : '0;

  if (!(DW == 8 || DW == 16 || DW == 32) || AW < 1 || AW > c_AW_MAX || TIMEOUT < 0)
  begin : g_param_check
    $error("apb4_master: unsupported AW/DW/TIMEOUT parameterisation");
  end

  apb_state_e       r_state;
  cmd_t             r_cmd;
  logic             r_psel;
  logic             r_penable;
  logic             r_rsp_valid;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_rsp_timeout;
  logic [c_CW-1:0]  r_wait_cnt;

  cmd_t             w_cmd;
  logic             w_accept;
  logic             w_tmo_hit;

  assign cmd_ready_o = !rst_i && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready_i));
  assign w_accept    = cmd_valid_i && cmd_ready_o;
  assign w_tmo_hit   = (TIMEOUT > 0) && (r_wait_cnt == c_TMO_LAST);

  // Reads carry no byte lanes, so the strobe is zeroed at capture time.
  always_comb begin
    w_cmd       = '0;
    w_cmd.addr  = c_AW_MAX'(cmd_addr_i);
    w_cmd.write = cmd_write_i;
    w_cmd.wdata = c_DW_MAX'(cmd_wdata_i);
    w_cmd.strb  = cmd_write_i ? c_SW_MAX'(cmd_strb_i) : '0;
    w_cmd.prot  = cmd_prot_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_cmd         <= '0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cmd      <= w_cmd;
            r_psel     <= 1'b1;
            r_penable  <= 1'b0;
            r_wait_cnt <= '0;
            r_state    <= SETUP;
          end
        end

        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end

        ACCESS: begin
          if (pready_i) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_cmd.write ? '0 : prdata_i;
            r_rsp_err     <= pslverr_i;
            r_rsp_timeout <= 1'b0;
            r_state       <= RESP;
          end else if (w_tmo_hit) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= RESP;
          end else if (r_wait_cnt != '1) begin
            r_wait_cnt <= r_wait_cnt + c_CW'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            // A command arriving with the handshake skips IDLE entirely.
            if (w_accept) begin
              r_cmd      <= w_cmd;
              r_psel     <= 1'b1;
              r_penable  <= 1'b0;
              r_wait_cnt <= '0;
              r_state    <= SETUP;
            end else begin
              r_state <= IDLE;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign paddr_o       = r_cmd.addr[AW-1:0];
  assign pprot_o       = r_cmd.prot;
  assign pwrite_o      = r_cmd.write;
  assign pwdata_o      = r_cmd.wdata[DW-1:0];
  assign pstrb_o       = r_cmd.strb[c_SW-1:0];
  assign psel_o        = r_psel;
  assign penable_o     = r_penable;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_timeout;

endmodule
`default_nettype wire
